// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port scheduler: merges pipeline WB and long-unit results, keeps a
// per-register scoreboard of pending long-unit destinations and stalls ID on RAW/WAW hazards.
// Latency: long result accepted at an edge can commit the next cycle. Backpressure: lu_ready
// drops while a result is held; pipeline WB always wins the port; a starved hold forces ID stall.
// Ports: clk/rst (sync, active-high); issue_* / Rs / Rt / use_rs / use_rt from ID, stall back to
// ID; wb_* from the WB stage; lu_valid/lu_ready/lu_reg/lu_data long-unit handshake;
// RegWrite/WriteReg/busW to the register file; busy exposes the scoreboard.
module regfile_wb_scheduler #(
  parameter int AW           = 5,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               issue_valid,
  input  logic               issue_wr,
  input  logic               issue_long,
  input  logic [AW-1:0]      issue_dest,
  input  logic [AW-1:0]      Rs,
  input  logic [AW-1:0]      Rt,
  input  logic               use_rs,
  input  logic               use_rt,
  output logic               stall,
  input  logic               wb_wr,
  input  logic [AW-1:0]      wb_reg,
  input  logic [DW-1:0]      wb_data,
  input  logic               lu_valid,
  output logic               lu_ready,
  input  logic [AW-1:0]      lu_reg,
  input  logic [DW-1:0]      lu_data,
  output logic               RegWrite,
  output logic [AW-1:0]      WriteReg,
  output logic [DW-1:0]      busW,
  output logic [2**AW-1:0]   busy
);

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [2:0]      starve_cnt, starve_cnt_nxt;
  logic            hold_valid;
  logic [AW-1:0]   hold_reg;
  logic [DW-1:0]   hold_data;
  logic            hazard;
  logic            commit;
  logic            accept;
  logic            set_busy;

  // The held result reaches the port only in cycles the pipeline leaves it free.
  assign commit   = hold_valid & ~wb_wr;
  assign lu_ready = ~hold_valid & ~rst;
  assign accept   = lu_valid & lu_ready;
  assign set_busy = issue_valid & ~stall & issue_wr & issue_long & (issue_dest != '0);

  // Hazards look at the registered scoreboard only: a result committing this cycle still
  // stalls its consumer for one more cycle, which keeps busy off the write-port timing path.
  always_comb begin
    hazard = 1'b0;
    if (use_rs && (Rs != '0) && busy[Rs])
      hazard = 1'b1;
    if (use_rt && (Rt != '0) && busy[Rt])
      hazard = 1'b1;
    if (issue_wr && (issue_dest != '0) && busy[issue_dest])
      hazard = 1'b1;
    if (state == DRAIN)
      hazard = 1'b1;
  end

  assign stall = rst | (issue_valid & hazard);

  always_comb begin
    RegWrite = 1'b0;
    WriteReg = '0;
    busW     = '0;
    if (rst) begin
      RegWrite = 1'b0;
    end else if (wb_wr) begin
      RegWrite = 1'b1;
      WriteReg = wb_reg;
      busW     = wb_data;
    end else if (hold_valid) begin
      // A result for r0 still occupies its commit slot but never writes.
      RegWrite = (hold_reg != '0);
      WriteReg = hold_reg;
      busW     = hold_data;
    end
  end

  // Clear is applied after set so that it wins if both ever hit the same register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (set_busy)
        busy[issue_dest] <= 1'b1;
      if (commit)
        busy[hold_reg] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_reg   <= '0;
      hold_data  <= '0;
    end else if (commit) begin
      hold_valid <= 1'b0;
    end else if (accept) begin
      hold_valid <= 1'b1;
      hold_reg   <= lu_reg;
      hold_data  <= lu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_cnt_nxt;
    end
  end

  // starve_cnt counts consecutive cycles the held result lost the port to WB.
  always_comb begin
    state_nxt      = state;
    starve_cnt_nxt = starve_cnt;
    if (commit) begin
      state_nxt      = IDLE;
      starve_cnt_nxt = '0;
    end else if (hold_valid && wb_wr) begin
      case (state)
        IDLE: begin
          starve_cnt_nxt = 3'd1;
          state_nxt      = (LIMIT <= 3'd1) ? DRAIN : WAIT;
        end
        WAIT: begin
          starve_cnt_nxt = starve_cnt + 3'd1;
          if (starve_cnt_nxt >= LIMIT)
            state_nxt = DRAIN;
        end
        DRAIN: begin
          state_nxt = DRAIN;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
module tb_regfile_wb_scheduler;

  localparam int AW  = 5;
  localparam int DW  = 32;
  localparam int LIM = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, issue_valid, issue_wr, issue_long, use_rs, use_rt, wb_wr, lu_valid;
  logic [AW-1:0] issue_dest, Rs, Rt, wb_reg, lu_reg;
  logic [DW-1:0] wb_data, lu_data;
  logic          stall, lu_ready, RegWrite;
  logic [AW-1:0] WriteReg;
  logic [DW-1:0] busW;
  logic [31:0]   busy;

  regfile_wb_scheduler #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_wr(issue_wr), .issue_long(issue_long),
    .issue_dest(issue_dest), .Rs(Rs), .Rt(Rt), .use_rs(use_rs), .use_rt(use_rt),
    .stall(stall),
    .wb_wr(wb_wr), .wb_reg(wb_reg), .wb_data(wb_data),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_reg(lu_reg), .lu_data(lu_data),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .busW(busW), .busy(busy)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: set of pending registers, at most one held result, and how many
  // consecutive cycles that result has been denied the port.
  logic [31:0] m_busy = '0;
  bit          m_hold = 1'b0;
  logic [4:0]  m_hreg = '0;
  logic [31:0] m_hdata = '0;
  int          m_wait = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_stall();
    if (rst) return 1'b1;
    if (!issue_valid) return 1'b0;
    if (use_rs && Rs != 0 && m_busy[Rs]) return 1'b1;
    if (use_rt && Rt != 0 && m_busy[Rt]) return 1'b1;
    if (issue_wr && issue_dest != 0 && m_busy[issue_dest]) return 1'b1;
    if (m_wait >= LIM) return 1'b1;
    return 1'b0;
  endfunction

  // Compare every output against the model for the current inputs.
  task automatic pre();
    bit          ew;
    logic [4:0]  ea;
    logic [31:0] ed;
    #1;
    ew = 1'b0; ea = '0; ed = '0;
    if (!rst && wb_wr) begin
      ew = 1'b1; ea = wb_reg; ed = wb_data;
    end else if (!rst && m_hold) begin
      ew = (m_hreg != 0); ea = m_hreg; ed = m_hdata;
    end
    chk("stall", 64'(stall), 64'(m_stall()));
    chk("lu_ready", 64'(lu_ready), 64'(!m_hold && !rst));
    chk("RegWrite", 64'(RegWrite), 64'(ew));
    chk("WriteReg", 64'(WriteReg), 64'(ea));
    chk("busW", 64'(busW), 64'(ed));
    if (!rst) chk("busy", 64'(busy), 64'(m_busy));
  endtask

  // Advance one clock and apply the same edge to the model.
  task automatic post();
    bit st, commit, accept;
    st = m_stall();
    @(posedge clk);
    if (rst) begin
      m_busy = '0; m_hold = 1'b0; m_wait = 0;
    end else begin
      commit = m_hold && !wb_wr;
      accept = lu_valid && !m_hold;
      if (issue_valid && !st && issue_wr && issue_long && issue_dest != 0)
        m_busy[issue_dest] = 1'b1;
      if (commit) begin
        m_busy[m_hreg] = 1'b0;
        m_hold = 1'b0;
        m_wait = 0;
      end else if (m_hold && wb_wr) begin
        m_wait++;
      end
      if (accept) begin
        m_hold = 1'b1; m_hreg = lu_reg; m_hdata = lu_data;
      end
    end
    @(negedge clk);
  endtask

  task automatic quiet();
    rst = 1'b0; issue_valid = 1'b0; issue_wr = 1'b0; issue_long = 1'b0;
    issue_dest = '0; Rs = '0; Rt = '0; use_rs = 1'b0; use_rt = 1'b0;
    wb_wr = 1'b0; wb_reg = '0; wb_data = '0;
    lu_valid = 1'b0; lu_reg = '0; lu_data = '0;
  endtask

  function automatic logic [4:0] pick();
    if ($urandom_range(0, 3) == 0) return 5'($urandom);
    return 5'($urandom_range(0, 3));
  endfunction

  initial begin
    quiet();

    // Reset with traffic present on both sources.
    rst = 1'b1; lu_valid = 1'b1; lu_reg = 5'd4; lu_data = 32'h55;
    wb_wr = 1'b1; wb_reg = 5'd3; wb_data = 32'h99;
    for (int i = 0; i < 2; i++) begin
      pre();
      chk("rst_stall", 64'(stall), 64'd1);
      chk("rst_lu_ready", 64'(lu_ready), 64'd0);
      chk("rst_regwrite", 64'(RegWrite), 64'd0);
      post();
    end
    rst = 1'b0; lu_valid = 1'b0;
    pre();
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_lu_ready", 64'(lu_ready), 64'd1);
    chk("post_rst_regwrite", 64'(RegWrite), 64'd1);
    post();

    // RAW on a long-unit destination.
    quiet();
    issue_valid = 1'b1; issue_wr = 1'b1; issue_long = 1'b1; issue_dest = 5'd5;
    pre(); chk("raw_issue_stall", 64'(stall), 64'd0); post();
    quiet();
    issue_valid = 1'b1; use_rs = 1'b1; Rs = 5'd5;
    lu_valid = 1'b1; lu_reg = 5'd5; lu_data = 32'hDEADBEEF;
    pre(); chk("raw_stall", 64'(stall), 64'd1); chk("raw_busy5", 64'(busy[5]), 64'd1); post();
    lu_valid = 1'b0;
    pre();
    chk("raw_commit_we", 64'(RegWrite), 64'd1);
    chk("raw_commit_reg", 64'(WriteReg), 64'd5);
    chk("raw_commit_data", 64'(busW), 64'hDEADBEEF);
    chk("raw_stall_commit", 64'(stall), 64'd1);
    post();
    pre(); chk("raw_release", 64'(stall), 64'd0); post();

    // WB beats a held long result.
    quiet();
    lu_valid = 1'b1; lu_reg = 5'd7; lu_data = 32'h11;
    pre(); post();
    quiet();
    wb_wr = 1'b1; wb_reg = 5'd3; wb_data = 32'h22;
    pre();
    chk("prio_reg", 64'(WriteReg), 64'd3);
    chk("prio_data", 64'(busW), 64'h22);
    chk("prio_lu_ready", 64'(lu_ready), 64'd0);
    post();
    wb_wr = 1'b0;
    pre();
    chk("prio_hold_reg", 64'(WriteReg), 64'd7);
    chk("prio_hold_data", 64'(busW), 64'h11);
    post();
    pre(); chk("prio_ready_again", 64'(lu_ready), 64'd1); post();

    // Starvation forces a drain.
    quiet();
    lu_valid = 1'b1; lu_reg = 5'd9; lu_data = 32'h33;
    pre(); post();
    quiet();
    issue_valid = 1'b1; wb_wr = 1'b1; wb_reg = 5'd2; wb_data = 32'h44;
    for (int i = 0; i < LIM; i++) begin
      pre(); chk("starve_no_stall", 64'(stall), 64'd0); post();
    end
    pre(); chk("drain_stall", 64'(stall), 64'd1); post();
    wb_wr = 1'b0;
    pre();
    chk("drain_commit_reg", 64'(WriteReg), 64'd9);
    chk("drain_stall_commit", 64'(stall), 64'd1);
    post();
    pre(); chk("drain_release", 64'(stall), 64'd0); post();

    // WAW on r31, then r0 as a destination.
    quiet();
    issue_valid = 1'b1; issue_wr = 1'b1; issue_long = 1'b1; issue_dest = 5'd31;
    pre(); post();
    issue_long = 1'b0;
    pre(); chk("waw_stall", 64'(stall), 64'd1); post();
    lu_valid = 1'b1; lu_reg = 5'd31; lu_data = 32'h77;
    pre(); chk("waw_stall_accept", 64'(stall), 64'd1); post();
    lu_valid = 1'b0;
    pre();
    chk("waw_commit_reg", 64'(WriteReg), 64'd31);
    chk("waw_stall_commit", 64'(stall), 64'd1);
    post();
    pre(); chk("waw_release", 64'(stall), 64'd0); post();
    quiet();
    issue_valid = 1'b1; issue_wr = 1'b1; issue_long = 1'b1; issue_dest = 5'd0;
    pre(); chk("r0_no_stall", 64'(stall), 64'd0); post();
    quiet();
    pre(); chk("r0_busy", 64'(busy), 64'd0); post();
    lu_valid = 1'b1; lu_reg = 5'd0; lu_data = 32'h88;
    pre(); post();
    lu_valid = 1'b0;
    pre();
    chk("r0_no_write", 64'(RegWrite), 64'd0);
    chk("r0_held", 64'(lu_ready), 64'd0);
    post();
    pre(); chk("r0_dropped", 64'(lu_ready), 64'd1); post();

    // Random traffic against the model, including occasional mid-run resets.
    for (int i = 0; i < 600; i++) begin
      rst         = ($urandom_range(0, 79) == 0);
      issue_valid = ($urandom_range(0, 3) != 0);
      issue_wr    = 1'($urandom);
      issue_long  = 1'($urandom);
      issue_dest  = pick();
      Rs          = pick();
      Rt          = pick();
      use_rs      = 1'($urandom);
      use_rt      = 1'($urandom);
      wb_wr       = ($urandom_range(0, 9) < (((i / 100) % 2 == 0) ? 3 : 9));
      wb_reg      = 5'($urandom);
      wb_data     = $urandom;
      lu_valid    = 1'($urandom);
      lu_reg      = pick();
      lu_data     = $urandom;
      pre();
      post();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
